alu_result_display: RTL and testbench

// - Downstream stage of the switch-driven 3-bit signed ALU (ops: 00 add, 01 sub, 10 and, 11 or).
// - On a rising edge of the sample switch, latches {A, B, F, result} and flags signed overflow.
// - Shows the latched result as sign plus magnitude on the 8-bit SEG bus.
// - On overflow, blinks the display for a fixed number of toggles, then holds it steady.

---
 rtl/alu_result_display_if.sv | 27 ++
 rtl/alu_result_display.sv | 141 ++++++++++++++
 tb/tb_alu_result_display.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/alu_result_display_if.sv
// Bundle between the switch-driven ALU and its result display stage.
// The master side drives the operands, result and sample switch, and observes the display.
// The slave side is the display stage.
interface alu_result_display_if #(
    parameter int NBITS_ALU = 3
);
    logic signed [NBITS_ALU-1:0] alu_a;
    logic signed [NBITS_ALU-1:0] alu_b;
    logic        [1:0]           alu_f;
    logic signed [NBITS_ALU-1:0] alu_result;
    logic                        sample;
    logic        [7:0]           seg;
    logic                        neg_led;
    logic                        ovf_led;
    logic                        busy;
    logic        [3:0]           cap_cnt;

    modport master (
        output alu_a, alu_b, alu_f, alu_result, sample,
        input  seg, neg_led, ovf_led, busy, cap_cnt
    );

    modport slave (
        input  alu_a, alu_b, alu_f, alu_result, sample,
        output seg, neg_led, ovf_led, busy, cap_cnt
    );
endinterface

// File: rtl/alu_result_display.sv
// Result display for the 3-bit signed ALU: latches the result on a rising edge of the
// sample switch, shows it as sign plus magnitude, and blinks for a while on overflow.
//
// state | meaning
// IDLE  | nothing captured since reset, display shows a dash
// SHOW  | latched result shown steadily
// ALERT | latched operation overflowed, display blinks, new captures ignored
module alu_result_display #(
    parameter int NBITS_ALU     = 3,
    parameter int BLINK_CYCLES  = 2,
    parameter int ALERT_TOGGLES = 6
) (
    input  logic                 clk_2,
    input  logic                 rst_n,
    alu_result_display_if.slave  bus
);
    localparam int CW = $clog2(BLINK_CYCLES + 1);
    localparam int TW = $clog2(ALERT_TOGGLES + 1);

    typedef enum logic [1:0] {IDLE, SHOW, ALERT} state_t;

    state_t                 state_q, state_d;
    logic                   sample_q;
    logic [NBITS_ALU-1:0]   r_q, r_d;
    logic                   ovf_q, ovf_d;
    logic [3:0]             cap_q, cap_d;
    logic [CW-1:0]          blink_q, blink_d;
    logic [TW-1:0]          tog_q, tog_d;
    logic                   blank_q, blank_d;

    logic                   rise;
    logic                   ovf_now;
    logic                   sa, sb, sr;
    logic [NBITS_ALU-1:0]   mag;
    logic [6:0]             pattern;

    assign rise = bus.sample & ~sample_q;
    assign sa   = bus.alu_a[NBITS_ALU-1];
    assign sb   = bus.alu_b[NBITS_ALU-1];
    assign sr   = bus.alu_result[NBITS_ALU-1];

    // Signed overflow of the operation currently presented by the ALU, judged from sign bits
    always_comb begin
        ovf_now = 1'b0;
        case (bus.alu_f)
            2'b00:   ovf_now = (sa == sb) && (sr != sa);
            2'b01:   ovf_now = (sa != sb) && (sr != sa);
            default: ovf_now = 1'b0;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sample_q <= 1'b0;
            r_q      <= '0;
            ovf_q    <= 1'b0;
            cap_q    <= '0;
            blink_q  <= '0;
            tog_q    <= '0;
            blank_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= bus.sample;
            r_q      <= r_d;
            ovf_q    <= ovf_d;
            cap_q    <= cap_d;
            blink_q  <= blink_d;
            tog_q    <= tog_d;
            blank_q  <= blank_d;
        end
    end

    // Next state: capture in IDLE/SHOW, blink timing in ALERT; a rise on the exit edge is dropped
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        cap_d   = cap_q;
        blink_d = blink_q;
        tog_d   = tog_q;
        blank_d = blank_q;
        case (state_q)
            IDLE, SHOW: begin
                if (rise) begin
                    r_d     = bus.alu_result;
                    ovf_d   = ovf_now;
                    cap_d   = cap_q + 4'd1;
                    blink_d = '0;
                    tog_d   = '0;
                    blank_d = 1'b0;
                    state_d = ovf_now ? ALERT : SHOW;
                end
            end
            ALERT: begin
                if (blink_q == CW'(BLINK_CYCLES - 1)) begin
                    blink_d = '0;
                    blank_d = ~blank_q;
                    tog_d   = tog_q + TW'(1);
                    if (tog_q == TW'(ALERT_TOGGLES - 1)) begin
                        blank_d = 1'b0;
                        state_d = SHOW;
                    end
                end else begin
                    blink_d = blink_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sign-magnitude decode; the most negative value maps to its own magnitude (-4 -> 4)
    always_comb begin
        mag     = r_q[NBITS_ALU-1] ? (~r_q) + NBITS_ALU'(1) : r_q;
        pattern = 7'h00;
        case (mag)
            3'd0:    pattern = 7'h3F;
            3'd1:    pattern = 7'h06;
            3'd2:    pattern = 7'h5B;
            3'd3:    pattern = 7'h4F;
            3'd4:    pattern = 7'h66;
            default: pattern = 7'h00;
        endcase
    end

    // Display outputs
    always_comb begin
        if (state_q == IDLE)
            bus.seg = 8'h40;
        else if (blank_q)
            bus.seg = 8'h00;
        else
            bus.seg = {r_q[NBITS_ALU-1], pattern};
    end

    assign bus.neg_led = r_q[NBITS_ALU-1];
    assign bus.ovf_led = ovf_q;
    assign bus.busy    = (state_q == ALERT);
    assign bus.cap_cnt = cap_q;
endmodule

// File: tb/tb_alu_result_display.sv
module tb_alu_result_display;
    localparam int BC = 2;
    localparam int AT = 6;

    logic clk_2 = 1'b0;
    logic rst_n = 1'b0;

    alu_result_display_if #(.NBITS_ALU(3)) bus ();

    alu_result_display #(
        .NBITS_ALU(3),
        .BLINK_CYCLES(BC),
        .ALERT_TOGGLES(AT)
    ) dut (
        .clk_2(clk_2),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk_2 = ~clk_2;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: mode 0 idle, 1 show, 2 alert; age counts edges since an overflow capture
    int m_mode, m_r, m_ovf, m_cap, m_age, m_prev;
    int patt [5] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sext3(input logic [2:0] v);
        return (v > 3'd3) ? int'(v) - 8 : int'(v);
    endfunction

    function automatic logic [2:0] alu_out(input int a, input int b, input int f);
        int r;
        case (f)
            0: r = a + b;
            1: r = a - b;
            2: r = a & b;
            default: r = a | b;
        endcase
        return r[2:0];
    endfunction

    function automatic int true_ovf(input int a, input int b, input int f);
        int t;
        if (f >= 2) return 0;
        t = (f == 0) ? a + b : a - b;
        return (t < -4 || t > 3) ? 1 : 0;
    endfunction

    function automatic logic [7:0] exp_seg();
        int mag;
        if (m_mode == 0) return 8'h40;
        if (m_mode == 2 && ((m_age / BC) % 2) == 1) return 8'h00;
        mag = (m_r < 0) ? -m_r : m_r;
        return {(m_r < 0) ? 1'b1 : 1'b0, 7'(patt[mag])};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_r = 0; m_ovf = 0; m_cap = 0; m_age = 0; m_prev = 0;
    endtask

    task automatic model_step();
        int rise;
        rise = (bus.sample && m_prev == 0) ? 1 : 0;
        m_prev = bus.sample ? 1 : 0;
        if (m_mode == 2) begin
            m_age++;
            if (m_age == BC * AT) m_mode = 1;
        end else if (rise != 0) begin
            m_r   = sext3(bus.alu_result);
            m_ovf = true_ovf(sext3(bus.alu_a), sext3(bus.alu_b), int'(bus.alu_f));
            m_cap = (m_cap + 1) % 16;
            m_mode = (m_ovf != 0) ? 2 : 1;
            m_age = 0;
        end
    endtask

    task automatic check_all();
        check("seg",     bus.seg,              exp_seg());
        check("neg_led", {7'd0, bus.neg_led},  (m_mode != 0 && m_r < 0) ? 8'd1 : 8'd0);
        check("ovf_led", {7'd0, bus.ovf_led},  8'(m_ovf));
        check("busy",    {7'd0, bus.busy},     (m_mode == 2) ? 8'd1 : 8'd0);
        check("cap_cnt", {4'd0, bus.cap_cnt},  8'(m_cap));
    endtask

    task automatic tick();
        @(posedge clk_2);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_op(input int a, input int b, input int f);
        bus.alu_a      = a[2:0];
        bus.alu_b      = b[2:0];
        bus.alu_f      = f[1:0];
        bus.alu_result = alu_out(a, b, f);
    endtask

    task automatic capture(input int a, input int b, input int f);
        set_op(a, b, f);
        bus.sample = 1'b1;
        tick();
        bus.sample = 1'b0;
    endtask

    int cap_before;

    initial begin
        model_reset();
        set_op(0, 0, 0);
        bus.sample = 1'b0;
        #2;
        check("rst_seg",  bus.seg,             8'h40);
        check("rst_busy", {7'd0, bus.busy},    8'd0);
        check("rst_cap",  {4'd0, bus.cap_cnt}, 8'd0);
        check("rst_ovf",  {7'd0, bus.ovf_led}, 8'd0);
        @(negedge clk_2);
        rst_n = 1'b1;
        repeat (2) tick();

        capture(2, 1, 0);
        check("add_seg", bus.seg, 8'h4F);
        check("add_cap", {4'd0, bus.cap_cnt}, 8'd1);
        tick();

        capture(-3, 2, 3);
        check("or_seg", bus.seg, 8'h86);
        check("or_neg", {7'd0, bus.neg_led}, 8'd1);
        tick();

        capture(3, 1, 0);
        check("ovf_seg",  bus.seg, 8'hE6);
        check("ovf_busy", {7'd0, bus.busy}, 8'd1);
        repeat (BC * AT + 2) tick();
        check("post_alert_seg",  bus.seg, 8'hE6);
        check("post_alert_busy", {7'd0, bus.busy}, 8'd0);
        check("post_alert_ovf",  {7'd0, bus.ovf_led}, 8'd1);

        capture(-4, 1, 1);
        check("sub_ovf", {7'd0, bus.ovf_led}, 8'd1);
        cap_before = m_cap;
        tick();
        capture(1, 1, 2);
        check("alert_ignore_cap", {4'd0, bus.cap_cnt}, 8'(cap_before));
        check("alert_ignore_r",   {7'd0, bus.neg_led}, 8'd0);
        repeat (BC * AT) tick();

        cap_before = m_cap;
        for (int i = 0; i < 16; i++) begin
            capture(i % 4, 3, 2);
            tick();
        end
        check("wrap_cap", {4'd0, bus.cap_cnt}, 8'(cap_before));

        cap_before = m_cap;
        set_op(-2, 1, 3);
        bus.sample = 1'b1;
        repeat (20) tick();
        bus.sample = 1'b0;
        tick();
        check("hold_one_cap", {4'd0, bus.cap_cnt}, 8'((cap_before + 1) % 16));

        for (int i = 0; i < 400; i++) begin
            set_op($urandom_range(7) - 4, $urandom_range(7) - 4, $urandom_range(3));
            bus.sample = ($urandom_range(2) == 0);
            tick();
        end
        bus.sample = 1'b0;
        repeat (BC * AT + 1) tick();

        capture(3, 1, 0);
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midalert_rst_seg",  bus.seg,             8'h40);
        check("midalert_rst_busy", {7'd0, bus.busy},    8'd0);
        check("midalert_rst_cap",  {4'd0, bus.cap_cnt}, 8'd0);
        #1;
        rst_n = 1'b1;
        repeat (2) tick();
        capture(-1, 0, 0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
